fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 43 ++++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode-side signals of the
// fetch stage. The master side is the fetch unit.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  br_taken,
        input  br_target,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output br_taken,
        output br_target,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding a 2-entry buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN: unaligned redirect halts fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic         misalign
`endif
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] FULL    = 2'(BUF_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tag_q, tag_d;
    logic        stale_q, stale_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        head_q, head_d;
    logic        mis_q, mis_d;
    logic [31:0] bpc_q [BUF_DEPTH];
    logic [31:0] bins_q [BUF_DEPTH];

    logic        redir;
    logic        trap;
    logic        req;
    logic        gnt;
    logic        rsp;
    logic        push;
    logic        pop;
    logic        wr_idx;
    logic [31:0] tgt;

    // A redirect in HALT is ignored: only reset leaves that state.
    assign redir = bus.br_taken && (state_q != ST_HALT);
    assign tgt   = {bus.br_target[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap     = redir && (bus.br_target[1:0] != 2'b00);
    assign misalign = mis_q;
`else
    logic unused_tgt_lo;
    assign unused_tgt_lo = ^bus.br_target[1:0];
    assign trap          = 1'b0;
`endif

    // One request in flight at most; buffer room counts the in-flight word.
    assign req = !rst && (state_q == ST_RUN) && !bus.br_taken
               && (cnt_q < FULL);
    assign gnt = req && bus.imem_gnt;
    assign rsp = (state_q == ST_WAIT) && bus.imem_rvalid;

    // Redirect wins over both buffer ports in the same cycle.
    assign push   = rsp && !stale_q && !redir;
    assign pop    = bus.id_valid && bus.id_ready && !redir;
    assign wr_idx = head_q ^ cnt_q[0];

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = (cnt_q != 2'd0);
    assign bus.id_instr  = bins_q[head_q];
    assign bus.id_pc     = bpc_q[head_q];

    // Next-state: fetch FSM, PC, stale tracking and buffer occupancy.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        stale_d = stale_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        mis_d   = mis_q;

        if (rsp) begin
            state_d = ST_RUN;
            stale_d = 1'b0;
        end

        if (gnt) begin
            state_d = ST_WAIT;
            pc_d    = pc_q + 32'd4;
            tag_d   = pc_q;
        end

        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end

        if (pop) begin
            head_d = ~head_q;
        end

        if (redir) begin
            pc_d   = tgt;
            cnt_d  = 2'd0;
            head_d = 1'b0;
            if ((state_q == ST_WAIT) && !bus.imem_rvalid) begin
                stale_d = 1'b1;
            end
            if (trap) begin
                state_d = ST_HALT;
                mis_d   = 1'b1;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            tag_q   <= 32'd0;
            stale_q <= 1'b0;
            cnt_q   <= 2'd0;
            head_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            stale_q <= stale_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            mis_q   <= mis_d;
        end
    end

    // Buffer storage: cleared on reset so decode sees zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                bpc_q[i]  <= 32'd0;
                bins_q[i] <= 32'd0;
            end
        end else if (push) begin
            bpc_q[wr_idx]  <= tag_q;
            bins_q[wr_idx] <= bus.imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with a scoreboard of expected PCs
// popped by a decode-side monitor.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus();

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign;
`endif

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    int lat = 1;
    int rcnt = 0;
    logic [31:0] raddr = 32'd0;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc + 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory: a grant seen mid-cycle answers lat cycles later.
    always @(negedge clk) begin
        if (bus.imem_req && bus.imem_gnt) begin
            rcnt  = lat;
            raddr = bus.imem_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.imem_rvalid = 1'b0;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = ins(raddr);
            end
        end
    end

    // Monitor: every accepted instruction must be the next expected PC.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && bus.id_valid && bus.id_ready && !bus.br_taken) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra got pc %h exp none", bus.id_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", bus.id_pc, e);
                chk("sb_instr", bus.id_instr, ins(e));
            end
        end
    end

    task automatic do_reset;
        rst            = 1'b1;
        bus.id_ready   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = 32'd0;
        bus.imem_gnt   = 1'b1;
        lat            = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_pc", bus.id_pc, 32'd0);
        chk("rst_instr", bus.id_instr, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_mis", 32'(misalign), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;

        // Streaming with decode always ready.
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("s1_req_c0", 32'(bus.imem_req), 32'd1);
        cyc(1);
        @(negedge clk);
        chk("s1_valid_c1", 32'(bus.id_valid), 32'd0);
        cyc(1);
        @(negedge clk);
        chk("s1_valid_c2", 32'(bus.id_valid), 32'd1);
        cyc(7);
        bus.id_ready = 1'b0;

        // Decode stalled: buffer fills, output held, then drains.
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("s2_hold_pc", bus.id_pc, 32'h0);
                chk("s2_hold_instr", bus.id_instr, ins(32'h0));
            end
            if (i >= 4) begin
                chk("s2_full_req", 32'(bus.imem_req), 32'd0);
            end
            cyc(1);
        end
        bus.id_ready = 1'b1;
        cyc(4);
        bus.id_ready = 1'b0;

        // Redirect while the request for 8 is in flight.
        do_reset();
        lat = 2;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        bus.id_ready = 1'b1;
        cyc(7);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h100;
        @(negedge clk);
        chk("s3_br_req", 32'(bus.imem_req), 32'd0);
        cyc(1);
        bus.br_taken = 1'b0;
        @(negedge clk);
        chk("s3_stale_req", 32'(bus.imem_req), 32'd0);
        chk("s3_stale_valid", 32'(bus.id_valid), 32'd0);
        cyc(1);
        @(negedge clk);
        chk("s3_tgt_req", 32'(bus.imem_req), 32'd1);
        chk("s3_tgt_addr", bus.imem_addr, 32'h100);
        cyc(7);
        bus.id_ready = 1'b0;

        // Redirect together with a pop from a full buffer.
        do_reset();
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        cyc(4);
        @(negedge clk);
        chk("s4_full_req", 32'(bus.imem_req), 32'd0);
        chk("s4_full_valid", 32'(bus.id_valid), 32'd1);
        cyc(1);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h200;
        bus.id_ready  = 1'b1;
        cyc(1);
        bus.br_taken = 1'b0;
        @(negedge clk);
        chk("s4_flush_valid", 32'(bus.id_valid), 32'd0);
        chk("s4_tgt_req", 32'(bus.imem_req), 32'd1);
        chk("s4_tgt_addr", bus.imem_addr, 32'h200);
        cyc(7);
        bus.id_ready = 1'b0;

        // PC wrap at the top of the address space.
        do_reset();
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        bus.id_ready  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hFFFF_FFF8;
        @(negedge clk);
        chk("s5_br_req", 32'(bus.imem_req), 32'd0);
        cyc(1);
        bus.br_taken = 1'b0;
        @(negedge clk);
        chk("s5_req", 32'(bus.imem_req), 32'd1);
        chk("s5_addr", bus.imem_addr, 32'hFFFF_FFF8);
        cyc(3);
        @(negedge clk);
        chk("s5_wrap_addr", bus.imem_addr, 32'h0);
        cyc(4);
        bus.id_ready = 1'b0;

        // Unaligned redirect target.
        do_reset();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h102;
        cyc(1);
        bus.br_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s6_mis", 32'(misalign), 32'd1);
            chk("s6_halt_req", 32'(bus.imem_req), 32'd0);
            chk("s6_halt_valid", 32'(bus.id_valid), 32'd0);
            cyc(1);
        end
`else
        @(negedge clk);
        chk("s6_req", 32'(bus.imem_req), 32'd1);
        chk("s6_addr", bus.imem_addr, 32'h100);
        cyc(1);
`endif

        // Reset with a request in flight; its late answer is ignored.
        do_reset();
        lat = 3;
        bus.id_ready = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("s7_req_h0", 32'(bus.imem_req), 32'd1);
        cyc(1);
        rst = 1'b1;
        @(negedge clk);
        chk("s7_rst_req", 32'(bus.imem_req), 32'd0);
        cyc(1);
        rst          = 1'b0;
        bus.imem_gnt = 1'b0;
        @(negedge clk);
        chk("s7_rel_req", 32'(bus.imem_req), 32'd1);
        cyc(1);
        @(negedge clk);
        chk("s7_late_valid", 32'(bus.id_valid), 32'd0);
        cyc(1);
        lat          = 1;
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        chk("s7_nopush_valid", 32'(bus.id_valid), 32'd0);
        cyc(3);
        bus.id_ready = 1'b0;
        cyc(4);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
